// File: rtl/avl_irq_ctrl.sv
// avl_irq_ctrl: Avalon-MM slave interrupt controller.
// Collects NUM_IRQ peripheral interrupt lines. Each line can be level or
// rising-edge qualified, masked, cleared by write-1-to-clear and triggered by
// software. The controller presents one fixed-priority request (bit 0 highest)
// with its source id, and holds it until an end-of-interrupt write or until
// the presented candidate disappears.
// Optional build macro IRQC_SYNC_EN: adds a two-flop synchronizer on every
// irq_in bit. Without it, irq_in is used directly and must already be
// registered on clk.
module avl_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out,
    output logic [4:0]         irq_id
);

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_ENABLE   = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [2:0] ADDR_RAW      = 3'd4;
    localparam logic [2:0] ADDR_SWTRIG   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Zero-extend a per-line vector to the 16-bit register width.
    function automatic logic [15:0] ext16(input logic [NUM_IRQ-1:0] v);
        logic [15:0] t;
        t = 16'h0000;
        t[NUM_IRQ-1:0] = v;
        return t;
    endfunction

    // Keep only the bits of a 16-bit write that map to real lines.
    function automatic logic [NUM_IRQ-1:0] lines_of(input logic [15:0] w);
        return w[NUM_IRQ-1:0];
    endfunction

    // One-hot mask for a line index.
    function automatic logic [NUM_IRQ-1:0] onehot(input logic [4:0] id);
        logic [NUM_IRQ-1:0] t;
        for (int i = 0; i < NUM_IRQ; i++) begin
            t[i] = (id == 5'(i));
        end
        return t;
    endfunction

    state_t             state_r;
    logic [4:0]         cur_id_r;
    logic [NUM_IRQ-1:0] enable_r;
    logic [NUM_IRQ-1:0] edge_sel_r;
    logic [NUM_IRQ-1:0] edge_pend_r;
    logic [NUM_IRQ-1:0] prev_r;
    logic [15:0]        readdata_r;
    logic               irq_out_r;
    logic [4:0]         irq_id_r;

    logic [NUM_IRQ-1:0] irq_s;
    logic               wr_s;
    logic               wr_pend_s;
    logic               wr_enable_s;
    logic               wr_edge_sel_s;
    logic               wr_swtrig_s;
    logic               eoi_hit_s;
    logic [NUM_IRQ-1:0] wdata_lines_s;
    logic [NUM_IRQ-1:0] enable_nxt_s;
    logic [NUM_IRQ-1:0] edge_sel_nxt_s;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] set_s;
    logic [NUM_IRQ-1:0] clr_s;
    logic [NUM_IRQ-1:0] edge_pend_nxt_s;
    logic [NUM_IRQ-1:0] pending_s;
    logic [NUM_IRQ-1:0] cand_s;
    logic [15:0]        cand_ext_s;
    logic               any_cand_s;
    logic [4:0]         sel_id_s;
    logic               cur_cand_s;
    logic [15:0]        rd_nxt_s;

`ifdef IRQC_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_r;
    logic [NUM_IRQ-1:0] sync2_r;

    // Two-flop synchronizer for asynchronous peripheral interrupt lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= {NUM_IRQ{1'b0}};
            sync2_r <= {NUM_IRQ{1'b0}};
        end else begin
            sync1_r <= irq_in;
            sync2_r <= sync1_r;
        end
    end

    assign irq_s = sync2_r;
`else
    assign irq_s = irq_in;
`endif

    assign wr_s          = chipselect & ~write_n;
    assign wdata_lines_s = lines_of(writedata);

    // Decode register writes and the end-of-interrupt match.
    always_comb begin
        wr_pend_s     = wr_s && (address == ADDR_PENDING);
        wr_enable_s   = wr_s && (address == ADDR_ENABLE);
        wr_edge_sel_s = wr_s && (address == ADDR_EDGE_SEL);
        wr_swtrig_s   = wr_s && (address == ADDR_SWTRIG);
        eoi_hit_s     = wr_s && (address == ADDR_ACTIVE) &&
                        (state_r == ST_ACTIVE) && (writedata[4:0] == cur_id_r);
    end

    // Next values of the configuration registers and the edge pending latch.
    // A set in the same cycle as a clear wins; bits leaving edge mode drop
    // their stored pending.
    always_comb begin
        if (wr_enable_s) begin
            enable_nxt_s = wdata_lines_s;
        end else begin
            enable_nxt_s = enable_r;
        end
        if (wr_edge_sel_s) begin
            edge_sel_nxt_s = wdata_lines_s;
        end else begin
            edge_sel_nxt_s = edge_sel_r;
        end
        rise_s = irq_s & ~prev_r;
        if (wr_swtrig_s) begin
            set_s = (rise_s | wdata_lines_s) & edge_sel_r;
        end else begin
            set_s = rise_s & edge_sel_r;
        end
        clr_s = {NUM_IRQ{1'b0}};
        if (wr_pend_s) begin
            clr_s = clr_s | wdata_lines_s;
        end else begin
            clr_s = clr_s;
        end
        if (eoi_hit_s) begin
            clr_s = clr_s | onehot(cur_id_r);
        end else begin
            clr_s = clr_s;
        end
        edge_pend_nxt_s = ((edge_pend_r & ~clr_s) | set_s) & edge_sel_nxt_s;
    end

    // Pending view, candidates and fixed-priority selection (lowest index wins).
    always_comb begin
        pending_s  = (edge_sel_r & edge_pend_r) | (~edge_sel_r & irq_s);
        cand_s     = pending_s & enable_r;
        cand_ext_s = ext16(cand_s);
        any_cand_s = |cand_s;
        cur_cand_s = cand_ext_s[cur_id_r[3:0]];
        sel_id_s   = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand_s[i]) begin
                sel_id_s = 5'(i);
            end else begin
                sel_id_s = sel_id_s;
            end
        end
    end

    // Configuration, edge pending and previous-sample registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_r    <= {NUM_IRQ{1'b0}};
            edge_sel_r  <= {NUM_IRQ{1'b0}};
            edge_pend_r <= {NUM_IRQ{1'b0}};
            prev_r      <= {NUM_IRQ{1'b0}};
        end else begin
            enable_r    <= enable_nxt_s;
            edge_sel_r  <= edge_sel_nxt_s;
            edge_pend_r <= edge_pend_nxt_s;
            prev_r      <= irq_s;
        end
    end

    // Request FSM: latch a source, hold it until EOI or withdrawal, then force
    // a one-cycle gap so irq_out always shows a low pulse between requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cur_id_r  <= 5'd0;
            irq_id_r  <= 5'd0;
            irq_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_cand_s) begin
                        state_r   <= ST_ACTIVE;
                        cur_id_r  <= sel_id_s;
                        irq_id_r  <= sel_id_s;
                        irq_out_r <= 1'b1;
                    end else begin
                        irq_out_r <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (eoi_hit_s) begin
                        state_r   <= ST_GAP;
                        irq_out_r <= 1'b0;
                    end else if (!cur_cand_s) begin
                        state_r   <= ST_IDLE;
                        irq_out_r <= 1'b0;
                    end else begin
                        irq_out_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    state_r   <= ST_IDLE;
                    irq_out_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    irq_out_r <= 1'b0;
                end
            endcase
        end
    end

    // Read data mux; unmapped addresses and unused bits read zero.
    always_comb begin
        case (address)
            ADDR_PENDING:  rd_nxt_s = ext16(pending_s);
            ADDR_ENABLE:   rd_nxt_s = ext16(enable_r);
            ADDR_EDGE_SEL: rd_nxt_s = ext16(edge_sel_r);
            ADDR_ACTIVE:   rd_nxt_s = {(state_r == ST_ACTIVE), 10'b0, cur_id_r};
            ADDR_RAW:      rd_nxt_s = ext16(irq_s);
            ADDR_SWTRIG:   rd_nxt_s = 16'h0000;
            default:       rd_nxt_s = 16'h0000;
        endcase
    end

    // Registered read data, captured every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 16'h0000;
        end else begin
            readdata_r <= rd_nxt_s;
        end
    end

    assign readdata = readdata_r;
    assign irq_out  = irq_out_r;
    assign irq_id   = irq_id_r;

endmodule
